bram_stream_reader: RTL

Read-side streaming engine for the team's simple dual-port block RAM. On a start command it walks a contiguous address range on the RAM read port, absorbs the RAM's fixed one-cycle read latency, and presents the words as a valid/ready stream with a last marker. It sits between a RAM filled by a producer on the write port and a downstream consumer that may apply backpressure.

---
 rtl/bram_reader_pkg.sv | 5 +
 rtl/bram_stream_reader_if.sv | 26 ++
 rtl/bram_reader_fifo2.sv | 33 +++
 rtl/bram_stream_reader.sv | 70 +++++++
 4 files changed

// File: rtl/bram_reader_pkg.sv
// bram_reader_pkg: shared state type and buffer depth for the BRAM stream reader
package bram_reader_pkg;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command, RAM read port and output stream of the reader
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  modport master (
    input  start, base_addr, length, rd_data, m_ready,
    output busy, done, rd_en, rd_addr, m_valid, m_data, m_last
  );
  modport slave (
    output start, base_addr, length, rd_data, m_ready,
    input  busy, done, rd_en, rd_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/bram_reader_fifo2.sv
// bram_reader_fifo2: two-entry synchronous FIFO absorbing the RAM read latency
module bram_reader_fifo2
  import bram_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic wp, rp;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '{default: '0};
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a RAM address range and streams the words out
// as a valid/ready stream with a last marker, hiding the one-cycle read latency.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic clk,
  input logic rst,
  bram_stream_reader_if.master bus
);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_cnt, last_addr;
  logic [ADDR_WIDTH:0]   issue_cnt, beat_cnt;
  logic [1:0]            count;
  logic                  inflight, accept, issue, pop;
  logic [DATA_WIDTH-1:0] head;
  assign accept = state == IDLE && bus.start;
  assign pop    = bus.m_valid && bus.m_ready;
  // a read goes out only if its data is sure to find a free slot when it lands
  assign issue  = state == RUN && (int'(count) + int'(inflight) < FIFO_DEPTH + int'(pop));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (accept ? (bus.length == '0 ? DONE : RUN) : IDLE)
            : state == RUN   ? (issue && issue_cnt == ONE ? FLUSH : RUN)
            : state == FLUSH ? (pop && bus.m_last ? DONE : FLUSH)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt  <= '0;
      last_addr <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        addr_cnt  <= bus.base_addr;
        issue_cnt <= bus.length;
        beat_cnt  <= bus.length;
      end
      if (issue) begin
        addr_cnt  <= addr_cnt + 1'b1;
        last_addr <= addr_cnt;
        issue_cnt <= issue_cnt - ONE;
      end
      if (pop) beat_cnt <= beat_cnt - ONE;
    end
  end
  bram_reader_fifo2 #(.WIDTH(DATA_WIDTH)) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (bus.rd_data),
    .dout  (head),
    .count (count)
  );
  assign bus.busy    = state == RUN || state == FLUSH;
  assign bus.done    = state == DONE;
  assign bus.rd_en   = issue;
  assign bus.rd_addr = issue ? addr_cnt : last_addr;
  assign bus.m_valid = count != 2'd0;
  assign bus.m_data  = head;
  assign bus.m_last  = bus.m_valid && beat_cnt == ONE;
endmodule
